function_dispatcher: RTL and testbench
======================================

// Module: function_dispatcher
// PURPOSE
//  Clocked initiator for the N-way function-chooser handshake: queues function indices, raises the
//  matching one-hot request level, waits for the chooser's fin, then pulses its clear and waits for
//  fin to drop before reporting completion. Sits between synchronous control and an async chooser
//  (set-on-req-rising-edge, clear-on-clr-rising-edge, fin = OR of all sets).
// PARAMETERS
//  N        2     number of functions (req_out width), N>=2
//  DEPTH    4     command FIFO depth, power of two, >=2
//  TIMEOUT  255   max clk cycles waited for a fin transition, 1..2**TO_W-1
//  TO_W     8     width of timeout counter
// PORTS
//  clk        in   1           system clock, all state on rising edge
//  rst        in   1           reset, asynchronous, active-high
//  cmd_valid  in   1           command present
//  cmd_ready  out  1           FIFO can accept (= !full)
//  cmd_idx    in   $clog2(N)   function index to dispatch
//  req_out    out  N           one-hot request level to chooser
//  clr_out    out  1           clear level to chooser (its rst)
//  fin_in     in   1           chooser fin, asynchronous
//  done_valid out  1           one-cycle completion pulse
//  done_idx   out  $clog2(N)   index of completed/failed command, valid with done_valid
//  done_err   out  1           completion was a timeout or bad index, valid with done_valid
//  fault      out  1           sticky: chooser failed to clear; only rst exits
//  busy       out  1           FSM not in IDLE or FIFO non-empty
// BEHAVIOUR
//  Reset: req_out=0, clr_out=0, done_*=0, fault=0, FIFO empty, sync flops 0, state IDLE.
//  fin_in passes a 2-flop synchroniser -> fin_s (2-cycle latency); FSM uses fin_s only.
//  FIFO: push when cmd_valid&&cmd_ready; cmd_ready from registered full only (no same-cycle
//   push-through when full). Pop only in IDLE. Pointers wrap mod DEPTH with extra MSB for full/empty.
//  FSM (all outputs registered):
//   IDLE: FIFO non-empty -> pop. idx>=N: done_valid=1,done_err=1, stay IDLE. Else latch idx,
//         req_out<=1<<idx, cnt<=0 -> REQ. Dispatch latency push->req_out = 2 cycles minimum.
//   REQ:  fin_s=1 -> req_out<=0, clr_out<=1, cnt<=0, err_l<=0 -> CLR.
//         cnt==TIMEOUT-1 w/o fin_s -> req_out<=0, clr_out<=1, err_l<=1, cnt<=0 -> CLR.
//   CLR:  fin_s=0 -> clr_out<=0, done_valid=1, done_idx=idx, done_err=err_l -> IDLE.
//         cnt==TIMEOUT-1 w/o fin_s falling -> clr_out<=0, fault<=1 -> FAULT.
//   FAULT: all outputs low except fault, busy=1; accepts no pops; exit only by rst.
//  Invariants: req_out at most one bit set; req_out and clr_out never both high; clr_out low >=1
//   cycle before any new req_out bit rises (IDLE cycle guarantees fresh rising edges).
//  fin_s already high on entry to REQ (stale set): treated as fin; sequence proceeds normally.
//  rst mid-operation: outputs drop immediately (async); queued commands lost; no done pulse.
//  cnt saturates logic not needed: width TO_W, compared against TIMEOUT-1.
// STRUCTURE
//  Package function_dispatcher_pkg: state enum {IDLE,REQ,CLR,FAULT}, IDX_W=$clog2(N) helper.
//  One sub-module: dispatch_fifo (DEPTH x IDX_W, registered full/empty, async rst).
//  Synchroniser and FSM inline in top.
// TESTING
//  Model chooser in bench: fin rises 3 clks after req edge, falls 2 clks after clr edge.
//  1 N=2, push idx 1 -> req_out=2'b10 two cycles later, clr_out after fin_s, done_valid idx=1 err=0.
//  2 push 0,1,0,1 back-to-back (DEPTH=4) -> cmd_ready low after 4th if none popped; 4 dones in order;
//    req_out=0 for >=1 cycle between each request; never req_out&&clr_out.
//  3 chooser never raises fin, TIMEOUT=8 -> clr_out after 8 REQ cycles, done_err=1, next cmd served.
//  4 fin stuck high after clr -> fault=1 after TIMEOUT, busy=1, no further req_out until rst.
//  5 N=3, push idx 3 -> immediate done_valid with done_err=1, req_out stays 0.
//  6 assert rst while in REQ -> req_out=0 same cycle, FIFO empty, state IDLE, no done pulse.

Source files
------------

// File: rtl/function_dispatcher_pkg.sv
// function_dispatcher_pkg
//   Shared types and helpers for the function dispatcher slice.
//   state_e : dispatcher FSM states.
//   idx_w   : width of a function index for an N-way chooser (never below 1).
package function_dispatcher_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    REQ   = 2'd1,
    CLR   = 2'd2,
    FAULT = 2'd3
  } state_e;

  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/dispatch_fifo.sv
// dispatch_fifo
//   Command FIFO holding function indices waiting for dispatch.
//   Full/empty are registered, so a push is never accepted on the strength of
//   a pop happening in the same cycle.
// Ports
//   clk     in   clock, rising edge
//   rst     in   asynchronous active-high reset (pointers and flags)
//   push_i  in   write request (ignored while full)
//   pop_i   in   read request (ignored while empty)
//   data_i  in   index to store
//   data_o  out  index at the head of the queue
//   full_o  out  registered full flag
//   empty_o out  registered empty flag
module dispatch_fifo
  import function_dispatcher_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [WIDTH-1:0] data_i,
  output logic [WIDTH-1:0] data_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic          full_q, full_d;
  logic          empty_q, empty_d;
  logic          do_push, do_pop;

  assign do_push = push_i && !full_q;
  assign do_pop  = pop_i && !empty_q;

  always_comb begin
    wr_ptr_d = wr_ptr_q + PW'(do_push);
    rd_ptr_d = rd_ptr_q + PW'(do_pop);
    empty_d  = (wr_ptr_d == rd_ptr_d);
    full_d   = (wr_ptr_d[AW] != rd_ptr_d[AW]) &&
               (wr_ptr_d[AW-1:0] == rd_ptr_d[AW-1:0]);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      full_q   <= full_d;
      empty_q  <= empty_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= data_i;
  end

  assign data_o  = mem_q[rd_ptr_q[AW-1:0]];
  assign full_o  = full_q;
  assign empty_o = empty_q;

endmodule

// File: rtl/function_dispatcher.sv
// function_dispatcher
//   Clocked initiator for the N-way function-chooser handshake. Queued indices
//   are dispatched one at a time: raise the one-hot request, wait for fin,
//   raise clear, wait for fin to drop, then report completion. A chooser that
//   never drops fin latches a sticky fault that only rst clears.
// Ports
//   clk        in   clock, rising edge
//   rst        in   asynchronous active-high reset
//   cmd_valid  in   command present
//   cmd_ready  out  FIFO can accept a command
//   cmd_idx    in   function index to dispatch
//   req_out    out  one-hot request level to the chooser
//   clr_out    out  clear level to the chooser
//   fin_in     in   chooser fin (asynchronous)
//   done_valid out  one-cycle completion pulse
//   done_idx   out  index of the completed command
//   done_err   out  completion was a timeout or a bad index
//   fault      out  sticky: chooser failed to clear
//   busy       out  FSM active or commands queued
module function_dispatcher
  import function_dispatcher_pkg::*;
#(
  parameter  int N       = 2,
  parameter  int DEPTH   = 4,
  parameter  int TIMEOUT = 255,
  parameter  int TO_W    = 8,
  localparam int IDX_W   = idx_w(N)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [IDX_W-1:0] cmd_idx,
  output logic [N-1:0]     req_out,
  output logic             clr_out,
  input  logic             fin_in,
  output logic             done_valid,
  output logic [IDX_W-1:0] done_idx,
  output logic             done_err,
  output logic             fault,
  output logic             busy
);

  // fin comes from the asynchronous chooser; two flops before the FSM sees it.
  logic fin_meta_q, fin_s_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fin_meta_q <= 1'b0;
      fin_s_q    <= 1'b0;
    end else begin
      fin_meta_q <= fin_in;
      fin_s_q    <= fin_meta_q;
    end
  end

  logic             fifo_full, fifo_empty, fifo_pop;
  logic [IDX_W-1:0] fifo_idx;

  dispatch_fifo #(.DEPTH(DEPTH), .WIDTH(IDX_W)) u_fifo (
    .clk    (clk),
    .rst    (rst),
    .push_i (cmd_valid),
    .pop_i  (fifo_pop),
    .data_i (cmd_idx),
    .data_o (fifo_idx),
    .full_o (fifo_full),
    .empty_o(fifo_empty)
  );

  assign cmd_ready = !fifo_full;

  state_e           state_q, state_d;
  logic [N-1:0]     req_q, req_d;
  logic             clr_q, clr_d;
  logic             done_valid_q, done_valid_d;
  logic [IDX_W-1:0] done_idx_q, done_idx_d;
  logic             done_err_q, done_err_d;
  logic             fault_q, fault_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             err_q, err_d;
  logic [TO_W-1:0]  cnt_q, cnt_d;
  logic             cnt_expired;

  assign cnt_expired = (cnt_q == TO_W'(TIMEOUT - 1));

  always_comb begin
    state_d      = state_q;
    req_d        = req_q;
    clr_d        = clr_q;
    done_valid_d = 1'b0;
    done_idx_d   = done_idx_q;
    done_err_d   = done_err_q;
    fault_d      = fault_q;
    idx_d        = idx_q;
    err_d        = err_q;
    cnt_d        = cnt_q;
    fifo_pop     = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          if (32'(fifo_idx) >= N) begin
            // Index has no chooser line: fail it without touching the chooser.
            done_valid_d = 1'b1;
            done_idx_d   = fifo_idx;
            done_err_d   = 1'b1;
          end else begin
            idx_d   = fifo_idx;
            req_d   = N'(1) << fifo_idx;
            cnt_d   = '0;
            state_d = REQ;
          end
        end
      end
      REQ: begin
        // A stale fin already high on entry is accepted as this request's fin.
        if (fin_s_q || cnt_expired) begin
          req_d   = '0;
          clr_d   = 1'b1;
          cnt_d   = '0;
          err_d   = !fin_s_q;
          state_d = CLR;
        end else begin
          cnt_d = cnt_q + TO_W'(1);
        end
      end
      CLR: begin
        if (!fin_s_q) begin
          clr_d        = 1'b0;
          done_valid_d = 1'b1;
          done_idx_d   = idx_q;
          done_err_d   = err_q;
          state_d      = IDLE;
        end else if (cnt_expired) begin
          clr_d   = 1'b0;
          fault_d = 1'b1;
          state_d = FAULT;
        end else begin
          cnt_d = cnt_q + TO_W'(1);
        end
      end
      FAULT: begin
        req_d = '0;
        clr_d = 1'b0;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      req_q        <= '0;
      clr_q        <= 1'b0;
      done_valid_q <= 1'b0;
      done_idx_q   <= '0;
      done_err_q   <= 1'b0;
      fault_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      req_q        <= req_d;
      clr_q        <= clr_d;
      done_valid_q <= done_valid_d;
      done_idx_q   <= done_idx_d;
      done_err_q   <= done_err_d;
      fault_q      <= fault_d;
    end
  end

  // Working registers are always reloaded before use, so they need no reset.
  always_ff @(posedge clk) begin
    idx_q <= idx_d;
    err_q <= err_d;
    cnt_q <= cnt_d;
  end

  assign req_out    = req_q;
  assign clr_out    = clr_q;
  assign done_valid = done_valid_q;
  assign done_idx   = done_idx_q;
  assign done_err   = done_err_q;
  assign fault      = fault_q;
  assign busy       = (state_q != IDLE) || !fifo_empty;

endmodule

// File: tb/tb_function_dispatcher.sv
module tb_function_dispatcher;
  localparam int N       = 3;
  localparam int DEPTH   = 4;
  localparam int TIMEOUT = 8;
  localparam int TO_W    = 8;
  localparam int IW      = 2;

  logic          clk = 1'b0;
  logic          rst;
  logic          cmd_valid = 1'b0;
  logic          cmd_ready;
  logic [IW-1:0] cmd_idx = '0;
  logic [N-1:0]  req_out;
  logic          clr_out;
  logic          fin_in;
  logic          done_valid;
  logic [IW-1:0] done_idx;
  logic          done_err;
  logic          fault;
  logic          busy;

  function_dispatcher #(.N(N), .DEPTH(DEPTH), .TIMEOUT(TIMEOUT), .TO_W(TO_W)) dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_idx(cmd_idx), .req_out(req_out), .clr_out(clr_out), .fin_in(fin_in),
    .done_valid(done_valid), .done_idx(done_idx), .done_err(done_err),
    .fault(fault), .busy(busy)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int done_cnt = 0;
  int run = 0;
  int last_run = 0;
  bit mode_nofin = 1'b0;
  bit mode_stuck = 1'b0;

  // Reference model: commands complete strictly in push order; bad index -> err.
  typedef struct { int idx; bit err; } exp_t;
  exp_t sb[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Chooser model: fin rises 3 clks after a req edge, falls 2 clks after a clr edge.
  logic [N-1:0] ch_req_prev;
  logic         ch_clr_prev;
  int           rcnt, fcnt;
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      fin_in <= 1'b0; rcnt <= 0; fcnt <= 0; ch_req_prev <= '0; ch_clr_prev <= 1'b0;
    end else begin
      ch_req_prev <= req_out;
      ch_clr_prev <= clr_out;
      if (((req_out & ~ch_req_prev) != '0) && !mode_nofin) rcnt <= 2;
      else if (rcnt > 1) rcnt <= rcnt - 1;
      else if (rcnt == 1) begin fin_in <= 1'b1; rcnt <= 0; end
      if (clr_out && !ch_clr_prev && !mode_stuck) fcnt <= 1;
      else if (fcnt == 1) begin fin_in <= 1'b0; fcnt <= 0; end
    end
  end

  // Continuous monitor: invariants and in-order completion scoreboard.
  logic [N-1:0] m_req_prev;
  logic         m_clr_prev;
  always @(negedge clk) begin
    if (rst) begin
      m_req_prev <= '0; m_clr_prev <= 1'b0; run <= 0;
    end else begin
      check("req_onehot", 64'($onehot0(req_out)), 1);
      check("req_clr_overlap", 64'(req_out != '0 && clr_out), 0);
      if (req_out != '0 && m_req_prev == '0) check("clr_low_before_req", m_clr_prev, 0);
      if (req_out != '0 && m_req_prev != '0) check("req_stable", req_out, m_req_prev);
      if (req_out != '0) begin
        if (sb.size() == 0) check("req_without_cmd", req_out, 0);
        else check("req_idx", req_out, 64'(N'(1) << sb[0].idx));
        run <= run + 1;
      end else if (m_req_prev != '0) begin
        last_run <= run;
        run <= 0;
      end
      if (fault) begin
        check("fault_req", req_out, 0);
        check("fault_clr", clr_out, 0);
        check("fault_busy", busy, 1);
      end
      if (done_valid) begin
        if (sb.size() == 0) check("unexpected_done", done_valid, 0);
        else begin
          check("done_idx", done_idx, sb[0].idx);
          check("done_err", done_err, sb[0].err);
          void'(sb.pop_front());
        end
        done_cnt <= done_cnt + 1;
      end
      m_req_prev <= req_out;
      m_clr_prev <= clr_out;
    end
  end

  task automatic tick(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic push(input int idx, input bit err);
    bit   acc;
    exp_t e;
    acc = 1'b0;
    cmd_valid = 1'b1;
    cmd_idx = IW'(idx);
    for (int k = 0; k < 50 && !acc; k++) begin
      @(negedge clk);
      acc = cmd_ready;
      @(posedge clk); #1;
    end
    cmd_valid = 1'b0;
    if (!acc) check("push_accept", 0, 1);
    else begin
      e.idx = idx; e.err = err;
      sb.push_back(e);
    end
  endtask

  task automatic wait_idle(input string name);
    int k;
    k = 0;
    while ((sb.size() != 0 || busy) && k < 300) begin tick(1); k++; end
    check(name, 64'(sb.size() == 0 && !busy), 1);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    cmd_valid = 1'b0;
    mode_nofin = 1'b0;
    mode_stuck = 1'b0;
    sb.delete();
    tick(2);
    check("rst_req", req_out, 0);
    check("rst_clr", clr_out, 0);
    check("rst_done_valid", done_valid, 0);
    check("rst_done_err", done_err, 0);
    check("rst_done_idx", done_idx, 0);
    check("rst_fault", fault, 0);
    check("rst_busy", busy, 0);
    check("rst_cmd_ready", cmd_ready, 1);
    rst = 1'b0;
    tick(1);
  endtask

  typedef struct { int idx; bit err; logic [N-1:0] req; } vec_t;
  vec_t vt[5];

  initial begin
    int d0;
    logic [N-1:0] seen;
    int k;

    do_reset();

    // Table-driven: each index alone, observed request line and completion.
    vt[0] = '{0, 1'b0, 3'b001};
    vt[1] = '{1, 1'b0, 3'b010};
    vt[2] = '{2, 1'b0, 3'b100};
    vt[3] = '{3, 1'b1, 3'b000};
    vt[4] = '{1, 1'b0, 3'b010};
    for (int i = 0; i < 5; i++) begin
      d0 = done_cnt;
      seen = '0;
      push(vt[i].idx, vt[i].err);
      k = 0;
      while (sb.size() != 0 && k < 100) begin seen |= req_out; tick(1); k++; end
      check("vec_req_seen", seen, vt[i].req);
      wait_idle("vec_idle");
      check("vec_done_count", done_cnt - d0, 1);
    end

    // Dispatch latency and the request/clear sequence.
    push(1, 1'b0);
    check("lat_req_after_push", req_out, 0);
    tick(1);
    check("lat_req_2cyc", req_out, 3'b010);
    k = 0;
    while (!clr_out && k < 30) begin tick(1); k++; end
    check("clr_seen", clr_out, 1);
    check("req_off_in_clr", req_out, 0);
    wait_idle("lat_idle");

    // Back-to-back pushes fill the FIFO behind the command in flight.
    d0 = done_cnt;
    push(0, 1'b0); push(1, 1'b0); push(0, 1'b0); push(1, 1'b0); push(0, 1'b0);
    check("full_cmd_ready", cmd_ready, 0);
    check("full_busy", busy, 1);
    wait_idle("b2b_idle");
    check("b2b_done_count", done_cnt - d0, 5);

    // Chooser never answers: timeout after TIMEOUT request cycles, then recovery.
    mode_nofin = 1'b1;
    push(2, 1'b1);
    wait_idle("to_idle");
    check("to_req_cycles", last_run, TIMEOUT);
    mode_nofin = 1'b0;
    d0 = done_cnt;
    push(0, 1'b0);
    wait_idle("to_next_idle");
    check("to_next_done", done_cnt - d0, 1);

    // Bad index completes immediately with error.
    push(3, 1'b1);
    check("bad_no_done_yet", done_valid, 0);
    tick(1);
    check("bad_done_valid", done_valid, 1);
    check("bad_done_err", done_err, 1);
    check("bad_done_idx", done_idx, 3);
    check("bad_req", req_out, 0);
    wait_idle("bad_idle");

    // fin stuck high after clear: sticky fault until rst.
    mode_stuck = 1'b1;
    push(1, 1'b0);
    k = 0;
    while (!fault && k < 80) begin tick(1); k++; end
    check("stuck_fault", fault, 1);
    check("stuck_busy", busy, 1);
    check("stuck_clr", clr_out, 0);
    push(0, 1'b0);
    tick(20);
    check("stuck_req_held", req_out, 0);
    check("stuck_fault_held", fault, 1);
    do_reset();

    // Reset while a request is raised.
    push(0, 1'b0);
    k = 0;
    while (req_out == '0 && k < 20) begin tick(1); k++; end
    check("rst_mid_req_up", 64'(req_out != '0), 1);
    d0 = done_cnt;
    #2;
    rst = 1'b1;
    sb.delete();
    #1;
    check("rst_mid_req", req_out, 0);
    check("rst_mid_busy", busy, 0);
    check("rst_mid_ready", cmd_ready, 1);
    tick(2);
    rst = 1'b0;
    tick(10);
    check("rst_mid_no_done", done_cnt - d0, 0);
    check("rst_mid_idle", busy, 0);

    // Randomised traffic against the in-order completion model.
    d0 = done_cnt;
    for (int i = 0; i < 30; i++) begin
      int ri;
      ri = int'($urandom_range(0, 3));
      push(ri, ri >= N);
      tick(int'($urandom_range(0, 3)));
    end
    wait_idle("rand_idle");
    check("rand_done_count", done_cnt - d0, 30);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

endmodule
